// File: rtl/vend_change_dispenser_pkg.sv
// Shared definitions for the coin-change dispenser: state encoding, coin values
// and datapath widths.
package vend_change_dispenser_pkg;

   localparam int MONEY_W = 12;
   localparam int STOCK_W = 8;
   localparam int TIMER_W = 16;

   localparam logic [MONEY_W-1:0] COIN_POUND = 12'd100;
   localparam logic [MONEY_W-1:0] COIN_20P   = 12'd20;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SELECT     = 3'd1,
      EJECT      = 3'd2,
      WAIT_SENSE = 3'd3,
      GAP        = 3'd4,
      FINISH     = 3'd5,
      JAM        = 3'd6
   } state_t;

   function automatic logic [MONEY_W-1:0] coin_value(input logic is_pound);
      return is_pound ? COIN_POUND : COIN_20P;
   endfunction

endpackage

// File: rtl/vend_cycle_timer.sv
// Loadable down-counter with a zero flag; a load wins over counting and the
// count parks at zero until reloaded.
module vend_cycle_timer
   import vend_change_dispenser_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   output logic               zero_o
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/vend_change_dispenser.sv
// Refund payout controller: ejects pound and 20p coins one at a time, waits for
// the exit sensor after each, and latches a sticky jam if a coin never appears.
//
// state      | meaning
// IDLE       | waiting for a refund_req rising edge; restock loads accepted
// SELECT     | pick the next coin from remaining and stock, or finish
// EJECT      | drive the selected eject output for PULSE_CYCLES
// WAIT_SENSE | wait up to TIMEOUT_CYCLES for the coin to pass the sensor
// GAP        | GAP_CYCLES settle time with ejects off
// FINISH     | one-cycle done pulse, short_paid valid
// JAM        | coin never sensed; frozen until reset
module vend_change_dispenser
   import vend_change_dispenser_pkg::*;
#(
   parameter int PULSE_CYCLES   = 4,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int INIT_POUND     = 10,
   parameter int INIT_20P       = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               refund_req,
   input  logic [MONEY_W-1:0] refund_amount,
   input  logic               coin_sensed,
   input  logic               load_pound,
   input  logic               load_20,
   output logic               coin_pound,
   output logic               coin_20,
   output logic               busy,
   output logic               done,
   output logic               short_paid,
   output logic               jam,
   output logic [MONEY_W-1:0] remaining,
   output logic [STOCK_W-1:0] stock_pound,
   output logic [STOCK_W-1:0] stock_20
);

   // Timer loads are N-1 because the loaded value itself counts as one cycle.
   localparam logic [TIMER_W-1:0] PULSE_LD   = TIMER_W'(PULSE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LD     = TIMER_W'(GAP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_LD = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [STOCK_W-1:0] POUND_FULL = STOCK_W'(INIT_POUND);
   localparam logic [STOCK_W-1:0] P20_FULL   = STOCK_W'(INIT_20P);

   state_t             state_q, state_d;
   logic [MONEY_W-1:0] remaining_q, remaining_d;
   logic [STOCK_W-1:0] stock_pound_q, stock_pound_d;
   logic [STOCK_W-1:0] stock_20_q, stock_20_d;
   logic               sel_pound_q, sel_pound_d;
   logic               short_paid_q, short_paid_d;
   logic               req_prev_q;

   logic               accept;
   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_val;
   logic               tmr_zero;
   logic [MONEY_W-1:0] sel_value;

   vend_cycle_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   assign accept    = (state_q == IDLE) && refund_req && !req_prev_q;
   assign sel_value = coin_value(sel_pound_q);

   always_comb begin
      state_d       = state_q;
      remaining_d   = remaining_q;
      stock_pound_d = stock_pound_q;
      stock_20_d    = stock_20_q;
      sel_pound_d   = sel_pound_q;
      short_paid_d  = short_paid_q;
      tmr_load      = 1'b0;
      tmr_val       = '0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d      = SELECT;
               remaining_d  = refund_amount;
               short_paid_d = 1'b0;
            end else begin
               if (load_pound) stock_pound_d = POUND_FULL;
               if (load_20)    stock_20_d    = P20_FULL;
            end
         end

         SELECT: begin
            if (remaining_q >= COIN_POUND && stock_pound_q != '0) begin
               sel_pound_d = 1'b1;
               state_d     = EJECT;
               tmr_load    = 1'b1;
               tmr_val     = PULSE_LD;
            end else if (remaining_q >= COIN_20P && stock_20_q != '0) begin
               sel_pound_d = 1'b0;
               state_d     = EJECT;
               tmr_load    = 1'b1;
               tmr_val     = PULSE_LD;
            end else begin
               state_d      = FINISH;
               short_paid_d = (remaining_q != '0);
            end
         end

         EJECT: begin
            if (tmr_zero) begin
               state_d  = WAIT_SENSE;
               tmr_load = 1'b1;
               tmr_val  = TIMEOUT_LD;
            end
         end

         WAIT_SENSE: begin
            if (coin_sensed) begin
               // Guards keep stock and remaining from wrapping even if the
               // selection rules were ever bypassed.
               if (sel_pound_q) begin
                  if (stock_pound_q != '0) stock_pound_d = stock_pound_q - 1'b1;
               end else begin
                  if (stock_20_q != '0) stock_20_d = stock_20_q - 1'b1;
               end
               if (remaining_q >= sel_value) remaining_d = remaining_q - sel_value;
               state_d  = GAP;
               tmr_load = 1'b1;
               tmr_val  = GAP_LD;
            end else if (tmr_zero) begin
               state_d = JAM;
            end
         end

         GAP: begin
            if (tmr_zero) state_d = SELECT;
         end

         FINISH: begin
            state_d = IDLE;
         end

         JAM: begin
            state_d = JAM;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         remaining_q   <= '0;
         stock_pound_q <= POUND_FULL;
         stock_20_q    <= P20_FULL;
         sel_pound_q   <= 1'b0;
         short_paid_q  <= 1'b0;
         req_prev_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         stock_pound_q <= stock_pound_d;
         stock_20_q    <= stock_20_d;
         sel_pound_q   <= sel_pound_d;
         short_paid_q  <= short_paid_d;
         req_prev_q    <= refund_req;
      end
   end

   assign coin_pound  = (state_q == EJECT) &&  sel_pound_q;
   assign coin_20     = (state_q == EJECT) && !sel_pound_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == FINISH);
   assign jam         = (state_q == JAM);
   assign short_paid  = short_paid_q;
   assign remaining   = remaining_q;
   assign stock_pound = stock_pound_q;
   assign stock_20    = stock_20_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed bench for the change dispenser: a table of payouts with
// hand-computed coin counts, plus sequences for reset, restock, jam and abort.
module tb_vend_change_dispenser;

   logic        clk;
   logic        reset;
   logic        refund_req;
   logic [11:0] refund_amount;
   logic        coin_sensed;
   logic        load_pound;
   logic        load_20;
   logic        coin_pound;
   logic        coin_20;
   logic        busy;
   logic        done;
   logic        short_paid;
   logic        jam;
   logic [11:0] remaining;
   logic [7:0]  stock_pound;
   logic [7:0]  stock_20;

   int checks = 0;
   int errors = 0;

   vend_change_dispenser #(
      .PULSE_CYCLES   (4),
      .GAP_CYCLES     (4),
      .TIMEOUT_CYCLES (1000),
      .INIT_POUND     (10),
      .INIT_20P       (20)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .refund_req    (refund_req),
      .refund_amount (refund_amount),
      .coin_sensed   (coin_sensed),
      .load_pound    (load_pound),
      .load_20       (load_20),
      .coin_pound    (coin_pound),
      .coin_20       (coin_20),
      .busy          (busy),
      .done          (done),
      .short_paid    (short_paid),
      .jam           (jam),
      .remaining     (remaining),
      .stock_pound   (stock_pound),
      .stock_20      (stock_20)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      int amt;
      int np;
      int n20;
      int sp;
      int rem;
      int s_pound;
      int s_20;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Runs one payout, answering each coin with coin_sensed in the 2nd
   // WAIT_SENSE cycle, and compares the result against table entry i.
   task automatic apply_vec(input int i);
      int  cyc, np, n20, hi, sense_at, sp_at_done;
      bit  got, both, prev_act, prev_pound, act;
      cyc = 0; np = 0; n20 = 0; hi = 0; sense_at = -1; sp_at_done = 0;
      got = 0; both = 0; prev_act = 0; prev_pound = 0;
      @(negedge clk);
      refund_amount = 12'(vecs[i].amt);
      refund_req    = 1'b1;
      @(negedge clk);
      refund_req    = 1'b0;
      while (!got && cyc < 400) begin
         if (coin_pound && coin_20) both = 1;
         act = coin_pound | coin_20;
         if (act) begin
            hi++;
            prev_pound = coin_pound;
         end else if (prev_act) begin
            chk($sformatf("v%0d_pulse_len", i), hi, 4);
            if (prev_pound) np++; else n20++;
            hi = 0;
            sense_at = cyc + 1;
         end
         coin_sensed = (cyc == sense_at);
         prev_act = act;
         if (done) begin
            got = 1;
            sp_at_done = int'(short_paid);
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      coin_sensed = 1'b0;
      chk($sformatf("v%0d_done_seen", i), int'(got), 1);
      chk($sformatf("v%0d_both_eject", i), int'(both), 0);
      chk($sformatf("v%0d_pounds", i), np, vecs[i].np);
      chk($sformatf("v%0d_20ps", i), n20, vecs[i].n20);
      chk($sformatf("v%0d_short_paid", i), sp_at_done, vecs[i].sp);
      chk($sformatf("v%0d_remaining", i), int'(remaining), vecs[i].rem);
      chk($sformatf("v%0d_stock_pound", i), int'(stock_pound), vecs[i].s_pound);
      chk($sformatf("v%0d_stock_20", i), int'(stock_20), vecs[i].s_20);
      @(negedge clk);
      chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
      chk($sformatf("v%0d_sp_held", i), int'(short_paid), vecs[i].sp);
   endtask

   initial begin
      int n, hi, w;
      bit got;

      //          amt  np n20 sp rem  s£  s20
      vecs[0] = '{260, 2, 3,  0, 0,   8,  17};
      vecs[1] = '{130, 1, 1,  1, 10,  7,  16};
      vecs[2] = '{0,   0, 0,  0, 0,   7,  16};
      vecs[3] = '{40,  0, 2,  0, 0,   7,  14};
      vecs[4] = '{600, 6, 0,  0, 0,   1,  14};
      vecs[5] = '{300, 1, 10, 0, 0,   0,  4};
      vecs[6] = '{150, 0, 4,  1, 70,  0,  0};
      vecs[7] = '{45,  0, 0,  1, 45,  0,  0};
      vecs[8] = '{15,  0, 0,  1, 15,  10, 20};
      vecs[9] = '{220, 2, 1,  0, 0,   8,  19};

      reset = 1'b1; refund_req = 1'b0; refund_amount = '0;
      coin_sensed = 1'b0; load_pound = 1'b0; load_20 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_coin_pound", int'(coin_pound), 0);
      chk("rst_coin_20", int'(coin_20), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_short_paid", int'(short_paid), 0);
      chk("rst_jam", int'(jam), 0);
      chk("rst_remaining", int'(remaining), 0);
      chk("rst_stock_pound", int'(stock_pound), 10);
      chk("rst_stock_20", int'(stock_20), 20);

      for (int i = 0; i < 8; i++) apply_vec(i);

      // Zero refund with loads held through the payout; refund_req stays high.
      @(negedge clk);
      refund_amount = 12'd0; refund_req = 1'b1;
      load_pound = 1'b1; load_20 = 1'b1;
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (n == 1) chk("zero_busy_next", int'(busy), 1);
         if (coin_pound || coin_20) chk("zero_no_eject", 1, 0);
         if (done) got = 1;
      end
      load_pound = 1'b0; load_20 = 1'b0;
      chk("zero_done_latency", n, 2);
      chk("zero_short_paid", int'(short_paid), 0);
      w = 0;
      repeat (5) begin
         @(negedge clk);
         if (busy) w++;
      end
      chk("held_req_ignored", w, 0);
      chk("busy_load_pound", int'(stock_pound), 0);
      chk("busy_load_20", int'(stock_20), 0);
      refund_req = 1'b0;

      load_pound = 1'b1;
      @(negedge clk);
      load_pound = 1'b0;
      chk("restock_pound", int'(stock_pound), 10);
      chk("restock_20_untouched", int'(stock_20), 0);
      load_20 = 1'b1;
      @(negedge clk);
      load_20 = 1'b0;
      chk("restock_20", int'(stock_20), 20);

      apply_vec(8);
      apply_vec(9);

      // Jam: no coin_sensed ever.
      @(negedge clk);
      refund_amount = 12'd100; refund_req = 1'b1;
      @(negedge clk);
      refund_req = 1'b0;
      n = 0;
      while (!coin_pound && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("jam_eject_seen", int'(coin_pound), 1);
      hi = 0;
      while (coin_pound && hi < 20) begin
         hi++;
         @(negedge clk);
      end
      chk("jam_pulse_len", hi, 4);
      w = 0;
      while (!jam && w < 1200) begin
         @(negedge clk);
         w++;
      end
      chk("jam_latency", w, 1000);
      coin_sensed = 1'b1;
      @(negedge clk);
      coin_sensed = 1'b0;
      @(negedge clk);
      chk("jam_sticky", int'(jam), 1);
      chk("jam_busy", int'(busy), 1);
      chk("jam_ejects_low", int'(coin_pound | coin_20), 0);
      chk("jam_stock_pound", int'(stock_pound), 8);
      chk("jam_remaining", int'(remaining), 100);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("jam_rst_jam", int'(jam), 0);
      chk("jam_rst_stock_pound", int'(stock_pound), 10);
      chk("jam_rst_stock_20", int'(stock_20), 20);

      // Reset during the second EJECT cycle abandons the payout.
      @(negedge clk);
      refund_amount = 12'd100; refund_req = 1'b1;
      @(negedge clk);
      refund_req = 1'b0;
      n = 0;
      while (!coin_pound && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("abort_eject_seen", int'(coin_pound), 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_coin_pound", int'(coin_pound), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_remaining", int'(remaining), 0);
      hi = 0;
      repeat (30) begin
         @(negedge clk);
         if (coin_pound || coin_20 || busy) hi++;
      end
      chk("abort_not_resumed", hi, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
